shift_add_mac: RTL

Sequential shift-add multiply-accumulate responder on the Start/Done strobe handshake used by the PID controller core. It computes out = a*b + acc, truncated to two's complement over 2N bits, one partial-product step per divided clock tick. The PID core drives the Start strobe and operands, then chains the 2N-bit result back into acc_i for its five-stage accumulation.

---
 rtl/shift_add_mac.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/shift_add_mac.sv
// shift_add_mac: sequential shift-add multiply-accumulate, out = a*b + acc mod 2^(2N).
// Takes one partial-product step per divided clock tick and always runs exactly
// 2N steps, so the latency is fixed. Pairs with the PID core through the
// Start/Done strobe handshake.
module shift_add_mac #(
   parameter int N                  = 41,
   parameter int CLK_DIV_MULTIPLIER = 50
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             MUL_Start_STRB_i,
   output logic             MUL_Done_STRB_o,
   input  logic [2*N-1:0]   a_i,
   input  logic [2*N-1:0]   b_i,
   input  logic [2*N-1:0]   acc_i,
   output logic [2*N-1:0]   out_o,
   output logic             busy_o
);

   localparam int W   = 2 * N;
   localparam int S_W = $clog2(W) + 1;
   localparam int D_W = $clog2(CLK_DIV_MULTIPLIER) + 1;

   localparam logic [S_W-1:0] S_LAST = S_W'(W - 1);
   localparam logic [D_W-1:0] D_LAST = D_W'(CLK_DIV_MULTIPLIER - 1);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;

   // Accumulates the addend only when the current multiplier LSB is set.
   function automatic logic [W-1:0] partial_sum(input logic [W-1:0] p,
                                                input logic [W-1:0] a,
                                                input logic         b_lsb);
      logic [W-1:0] r;
      if (b_lsb) begin
         r = p + a;
      end else begin
         r = p;
      end
      return r;
   endfunction

   logic           state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   p_q, p_d;
   logic [S_W-1:0] s_q, s_d;
   logic [D_W-1:0] d_q, d_d;
   logic [W-1:0]   out_q, out_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;

   logic           step_s;
   logic [W-1:0]   p_next_s;

   assign step_s   = (d_q == D_LAST);
   assign p_next_s = partial_sum(p_q, a_q, b_q[0]);

   // Next-state logic: operand capture in IDLE, divided shift-add steps in BUSY.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      s_d     = s_q;
      d_d     = d_q;
      out_d   = out_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (MUL_Start_STRB_i) begin
               a_d     = a_i;
               b_d     = b_i;
               p_d     = acc_i;
               s_d     = '0;
               d_d     = '0;
               state_d = ST_BUSY;
               busy_d  = 1'b1;
            end else begin
               busy_d  = 1'b0;
            end
         end
         ST_BUSY: begin
            if (step_s) begin
               d_d = '0;
               p_d = p_next_s;
               a_d = a_q << 1;
               b_d = b_q >> 1;
               s_d = s_q + S_W'(1);
               if (s_q == S_LAST) begin
                  out_d   = p_next_s;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  busy_d  = 1'b1;
               end
            end else begin
               d_d    = d_q + D_W'(1);
               busy_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any computation in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         s_q     <= '0;
         d_q     <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         s_q     <= s_d;
         d_q     <= d_d;
         out_q   <= out_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign out_o           = out_q;
   assign MUL_Done_STRB_o = done_q;
   assign busy_o          = busy_q;

endmodule
